// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_pkg
//  Description : Shared types and constants for the intruder-alarm sequencer:
//                FSM state encoding, sensor zone indices and helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg;

    // Width of the FSM state code as seen on the state output.
    localparam int STATE_W = 3;

    // Number of sensor zones (motion, door, window).
    localparam int ZONE_W = 3;

    // Zone bit positions within the sensor / zone vectors.
    localparam int Z_MOTION = 0;
    localparam int Z_DOOR   = 1;
    localparam int Z_WINDOW = 2;

    // FSM state encodings; codes 6 and 7 are unused and recover to DISARMED.
    typedef enum logic [STATE_W-1:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4,
        ST_HOLD     = 3'd5
    } alarm_state_t;

    // Motion and window are "instant" zones: they never get an entry delay.
    function automatic logic is_immediate(input logic [ZONE_W-1:0] s);
        return s[Z_MOTION] | s[Z_WINDOW];
    endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_sync.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_sync
//  Description : Parameterised-width two-flop synchronizer for raw
//                asynchronous inputs, asynchronous active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_d;
    logic [WIDTH-1:0] sync_q;

    // First stage captures the raw input, second stage resolves metastability.
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    // Synchronizer flops; both stages clear together on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule
`default_nettype wire

// File: rtl/alarm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_sequencer
//  Description : Arming/disarming controller for the motion/door/window
//                intruder alarm. Synchronises the sensors and runs the timed
//                exit / armed / entry / siren / hold state machine.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int EXIT_CYCLES  = 16,
    parameter int ENTRY_CYCLES = 16,
    parameter int SIREN_CYCLES = 64,
    parameter int CNT_W        = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   sensor,
    input  logic         arm,
    input  logic         disarm,
    output logic [2:0]   state,
    output logic         armed,
    output logic         siren,
    output logic         alarm_mem,
    output logic         buzzer,
    output logic [2:0]   zone,
    output logic         arm_fault
);

    // Counter load values: the counter runs from N-1 down to 0, so a phase
    // entered at edge k is left at edge k+N.
    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_CYCLES - 1);
    localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // State is held as a raw code so the illegal encodings stay observable
    // and can be steered back to DISARMED.
    logic [STATE_W-1:0] state_d;
    logic [STATE_W-1:0] state_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [ZONE_W-1:0]  zone_d;
    logic [ZONE_W-1:0]  zone_q;
    logic               arm_fault_d;
    logic               arm_fault_q;

    logic [ZONE_W-1:0]  w_s;
    logic               w_cnt_done;
    logic               w_instant;
    logic               w_any;

    // Sensors are asynchronous to clk; the FSM only ever sees w_s.
    alarm_sync #(
        .WIDTH    (ZONE_W)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (sensor),
        .sync_out (w_s)
    );

    assign w_cnt_done = (cnt_q == '0);
    assign w_instant  = is_immediate(w_s);
    assign w_any      = |w_s;

    // State, delay counter, zone latch and fault pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_DISARMED;
            cnt_q       <= '0;
            zone_q      <= '0;
            arm_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            zone_q      <= zone_d;
            arm_fault_q <= arm_fault_d;
        end
    end

    // Next-state, counter and zone logic; disarm overrides every state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        zone_d      = zone_q;
        arm_fault_d = 1'b0;

        if (disarm) begin
            // Zone record is intentionally kept so the user can see what
            // tripped after disarming. Arm+disarm in DISARMED lands here too,
            // which is why it never raises a fault.
            state_d = ST_DISARMED;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    if (arm) begin
                        if (!w_any) begin
                            state_d = ST_EXIT;
                            cnt_d   = EXIT_LOAD;
                            zone_d  = '0;
                        end else begin
                            // Refuse to arm over an open zone.
                            arm_fault_d = 1'b1;
                        end
                    end
                end

                ST_EXIT: begin
                    // Occupant is leaving: sensors are deliberately ignored.
                    if (w_cnt_done) begin
                        state_d = ST_ARMED;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end

                ST_ARMED: begin
                    if (w_instant) begin
                        // Instant zones beat the door when both are active.
                        state_d = ST_ALARM;
                        cnt_d   = SIREN_LOAD;
                        zone_d  = zone_q | w_s;
                    end else if (w_s[Z_DOOR]) begin
                        state_d = ST_ENTRY;
                        cnt_d   = ENTRY_LOAD;
                        zone_d  = zone_q | w_s;
                    end
                end

                ST_ENTRY: begin
                    zone_d = zone_q | w_s;
                    if (w_instant || w_cnt_done) begin
                        state_d = ST_ALARM;
                        cnt_d   = SIREN_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end

                ST_ALARM: begin
                    // Further sensor activity is recorded but does not extend
                    // the siren.
                    zone_d = zone_q | w_s;
                    if (w_cnt_done) begin
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end

                ST_HOLD: begin
                    if (w_any) begin
                        state_d = ST_ALARM;
                        cnt_d   = SIREN_LOAD;
                        zone_d  = zone_q | w_s;
                    end
                end

                default: begin
                    state_d = ST_DISARMED;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output decode from registered state only; no input-to-output path.
    always_comb begin
        state     = state_q;
        armed     = (state_q == ST_ARMED) || (state_q == ST_ENTRY);
        siren     = (state_q == ST_ALARM);
        alarm_mem = (state_q == ST_ALARM) || (state_q == ST_HOLD);
        buzzer    = (state_q == ST_EXIT)  || (state_q == ST_ENTRY);
        zone      = zone_q;
        arm_fault = arm_fault_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_alarm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_sequencer
//  Description : Self-checking bench for alarm_sequencer with a phase-based
//                reference model (phase + cycles remaining + sensor delay
//                line) and directed plus randomized scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_sequencer;

    localparam int EXIT  = 4;
    localparam int ENTRY = 3;
    localparam int SIREN = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sensor = 3'b000;
    logic       arm = 1'b0;
    logic       disarm = 1'b0;

    logic [2:0] state;
    logic       armed;
    logic       siren;
    logic       alarm_mem;
    logic       buzzer;
    logic [2:0] zone;
    logic       arm_fault;

    int total = 0;
    int bad   = 0;

    alarm_sequencer #(
        .EXIT_CYCLES  (EXIT),
        .ENTRY_CYCLES (ENTRY),
        .SIREN_CYCLES (SIREN),
        .CNT_W        (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sensor    (sensor),
        .arm       (arm),
        .disarm    (disarm),
        .state     (state),
        .armed     (armed),
        .siren     (siren),
        .alarm_mem (alarm_mem),
        .buzzer    (buzzer),
        .zone      (zone),
        .arm_fault (arm_fault)
    );

    always #5 clk = ~clk;

    // Reference model: phase code, cycles left in the timed phase, zone
    // record, fault flag and the two-edge sensor delay line.
    int         m_ph;
    int         m_left;
    logic [2:0] m_zone;
    logic       m_fault;
    logic [2:0] m_p1;
    logic [2:0] m_p2;

    task automatic model_reset();
        m_ph = 0; m_left = 0; m_zone = 3'b000; m_fault = 1'b0;
        m_p1 = 3'b000; m_p2 = 3'b000;
    endtask

    task automatic model_edge(input logic [2:0] sen, input logic a, input logic d);
        logic [2:0] s;
        logic       inst;
        s = m_p2;
        m_p2 = m_p1;
        m_p1 = sen;
        inst = s[0] | s[2];
        m_fault = 1'b0;
        if (d) begin
            m_ph = 0;
        end else begin
            case (m_ph)
                0: if (a) begin
                       if (s == 3'b000) begin m_ph = 1; m_left = EXIT; m_zone = 3'b000; end
                       else m_fault = 1'b1;
                   end
                1: if (m_left == 1) m_ph = 2; else m_left--;
                2: if (inst) begin m_ph = 4; m_left = SIREN; m_zone |= s; end
                   else if (s[1]) begin m_ph = 3; m_left = ENTRY; m_zone |= s; end
                3: begin
                       m_zone |= s;
                       if (inst || m_left == 1) begin m_ph = 4; m_left = SIREN; end
                       else m_left--;
                   end
                4: begin
                       m_zone |= s;
                       if (m_left == 1) m_ph = 5; else m_left--;
                   end
                5: if (s != 3'b000) begin m_ph = 4; m_left = SIREN; m_zone |= s; end
                default: m_ph = 0;
            endcase
        end
    endtask

    function automatic logic [10:0] dut_vec();
        return {state, armed, siren, alarm_mem, buzzer, zone, arm_fault};
    endfunction

    function automatic logic [10:0] model_vec();
        logic [2:0] st;
        st = 3'(m_ph);
        return {st, (m_ph == 2 || m_ph == 3), (m_ph == 4), (m_ph == 4 || m_ph == 5),
                (m_ph == 1 || m_ph == 3), m_zone, m_fault};
    endfunction

    // Advance one clock; model consumes the inputs present at the edge,
    // outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge(sensor, arm, disarm);
        #1;
    endtask

    task automatic settle_disarmed();
        sensor = 3'b000; arm = 1'b0; disarm = 1'b1;
        repeat (3) tick();
        disarm = 1'b0;
    endtask

    task automatic arm_now();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (EXIT) tick();
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (dut_vec() !== 11'd0) begin bad++; $display("FAIL reset_in got=%b want=%b", dut_vec(), 11'd0); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (dut_vec() !== model_vec()) begin bad++; $display("FAIL reset_out got=%b want=%b", dut_vec(), model_vec()); end
    endtask

    task automatic test_arm_exit();
        int n;
        settle_disarmed();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        n = 0;
        while (buzzer && n < 20) begin
            total++;
            if (dut_vec() !== model_vec()) begin bad++; $display("FAIL exit_cycle got=%b want=%b", dut_vec(), model_vec()); end
            n++;
            tick();
        end
        total++;
        if (n !== EXIT) begin bad++; $display("FAIL exit_len got=%0d want=%0d", n, EXIT); end
        total++;
        if ({state, armed, zone} !== {3'd2, 1'b1, 3'b000}) begin
            bad++; $display("FAIL armed_after_exit got=%b want=%b", {state, armed, zone}, {3'd2, 1'b1, 3'b000});
        end
    endtask

    task automatic test_window_trip();
        int n;
        int hi;
        sensor = 3'b100;
        n = 0;
        do begin
            tick();
            n++;
            total++;
            if (dut_vec() !== model_vec()) begin bad++; $display("FAIL win_lat got=%b want=%b", dut_vec(), model_vec()); end
        end while (!siren && n < 10);
        total++;
        if (n !== 3) begin bad++; $display("FAIL win_latency got=%0d want=3", n); end
        hi = 0;
        while (siren && hi < 20) begin
            hi++;
            tick();
            total++;
            if (dut_vec() !== model_vec()) begin bad++; $display("FAIL win_alarm got=%b want=%b", dut_vec(), model_vec()); end
        end
        total++;
        if (hi !== SIREN) begin bad++; $display("FAIL win_siren_len got=%0d want=%0d", hi, SIREN); end
        total++;
        if ({state, siren, alarm_mem, zone} !== {3'd5, 1'b0, 1'b1, 3'b100}) begin
            bad++; $display("FAIL win_hold got=%b want=%b", {state, siren, alarm_mem, zone}, {3'd5, 1'b0, 1'b1, 3'b100});
        end
        settle_disarmed();
    endtask

    task automatic test_entry_disarm();
        int n;
        int e;
        logic saw;
        for (int run = 0; run < 2; run++) begin
            settle_disarmed();
            arm_now();
            sensor = 3'b010;
            tick();
            sensor = 3'b000;
            n = 1;
            while (state == 3'd2 && n < 10) begin tick(); n++; end
            total++;
            if (n !== 3) begin bad++; $display("FAIL door_latency run=%0d got=%0d want=3", run, n); end
            e = 0;
            saw = 1'b0;
            while (state == 3'd3 && e < 10) begin
                e++;
                total++;
                if (dut_vec() !== model_vec()) begin bad++; $display("FAIL entry_cycle got=%b want=%b", dut_vec(), model_vec()); end
                if (run == 0 && e == 2) disarm = 1'b1;
                tick();
                if (siren) saw = 1'b1;
            end
            disarm = 1'b0;
            if (run == 0) begin
                total++;
                if ({state, saw, zone} !== {3'd0, 1'b0, 3'b010} || e > ENTRY) begin
                    bad++; $display("FAIL entry_disarm got=%b/%0d want=%b/<=%0d", {state, saw, zone}, e, {3'd0, 1'b0, 3'b010}, ENTRY);
                end
            end else begin
                total++;
                if (e !== ENTRY || state !== 3'd4) begin
                    bad++; $display("FAIL entry_full got=%0d/%0d want=%0d/4", e, state, ENTRY);
                end
            end
        end
        settle_disarmed();
    endtask

    task automatic test_door_motion();
        int n;
        arm_now();
        sensor = 3'b011;
        tick();
        sensor = 3'b000;
        n = 1;
        while (state == 3'd2 && n < 10) begin tick(); n++; end
        total++;
        if ({state, zone} !== {3'd4, 3'b011}) begin
            bad++; $display("FAIL door_motion got=%b want=%b", {state, zone}, {3'd4, 3'b011});
        end
        total++;
        if (dut_vec() !== model_vec()) begin bad++; $display("FAIL door_motion_vec got=%b want=%b", dut_vec(), model_vec()); end
        settle_disarmed();
    endtask

    task automatic test_arm_refused();
        sensor = 3'b010;
        repeat (3) tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        total++;
        if ({arm_fault, state} !== {1'b1, 3'd0}) begin
            bad++; $display("FAIL refuse_pulse got=%b want=%b", {arm_fault, state}, {1'b1, 3'd0});
        end
        tick();
        total++;
        if ({arm_fault, state} !== {1'b0, 3'd0}) begin
            bad++; $display("FAIL refuse_end got=%b want=%b", {arm_fault, state}, {1'b0, 3'd0});
        end
        arm = 1'b1;
        disarm = 1'b1;
        tick();
        total++;
        if ({arm_fault, state} !== {1'b0, 3'd0}) begin
            bad++; $display("FAIL arm_and_disarm got=%b want=%b", {arm_fault, state}, {1'b0, 3'd0});
        end
        total++;
        if (dut_vec() !== model_vec()) begin bad++; $display("FAIL refuse_vec got=%b want=%b", dut_vec(), model_vec()); end
        arm = 1'b0;
        disarm = 1'b0;
        settle_disarmed();
    endtask

    task automatic test_hold_retrigger();
        int n;
        int hi;
        arm_now();
        sensor = 3'b100;
        tick();
        sensor = 3'b000;
        n = 0;
        while (state != 3'd5 && n < 20) begin tick(); n++; end
        total++;
        if (dut_vec() !== model_vec() || state !== 3'd5) begin
            bad++; $display("FAIL reach_hold got=%b want=%b", dut_vec(), model_vec());
        end
        sensor = 3'b001;
        tick();
        sensor = 3'b000;
        n = 0;
        while (!siren && n < 10) begin tick(); n++; end
        hi = 0;
        while (siren && hi < 20) begin
            hi++;
            total++;
            if (dut_vec() !== model_vec()) begin bad++; $display("FAIL retrig_cycle got=%b want=%b", dut_vec(), model_vec()); end
            tick();
        end
        total++;
        if (hi !== SIREN || zone !== 3'b101) begin
            bad++; $display("FAIL retrigger got=%0d/%b want=%0d/101", hi, zone, SIREN);
        end
        settle_disarmed();
    endtask

    task automatic test_async_reset();
        int n;
        arm_now();
        sensor = 3'b001;
        tick();
        sensor = 3'b000;
        n = 0;
        while (!siren && n < 10) begin tick(); n++; end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (dut_vec() !== 11'd0) begin bad++; $display("FAIL async_reset got=%b want=%b", dut_vec(), 11'd0); end
        tick();
        total++;
        if (dut_vec() !== model_vec()) begin bad++; $display("FAIL reset_held got=%b want=%b", dut_vec(), model_vec()); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (dut_vec() !== model_vec()) begin bad++; $display("FAIL reset_release got=%b want=%b", dut_vec(), model_vec()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            sensor = ($urandom_range(0, 99) < 85) ? 3'b000 : 3'($urandom_range(1, 7));
            arm    = ($urandom_range(0, 9) == 0);
            disarm = ($urandom_range(0, 39) == 0);
            tick();
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL random cyc=%0d got=%b want=%b", i, dut_vec(), model_vec());
            end
        end
        arm = 1'b0;
        disarm = 1'b0;
        sensor = 3'b000;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_arm_exit();
        test_window_trip();
        test_entry_disarm();
        test_door_motion();
        test_arm_refused();
        test_hold_retrigger();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/alarm_sequencer.md
# alarm_sequencer

Arming/disarming controller for the motion/door/window intruder-alarm datapath. It synchronises the three raw sensor inputs and runs the timed state machine: exit delay, armed watch, entry delay, siren and latched alarm. It drives the siren and status outputs that the top-level wrapper maps onto `uo_out`. The block sits between the `ui_in` pins and the output pins inside the `tt_um_` top.

## Interface

Parameters:
- `EXIT_CYCLES`, default 16 — length of the exit delay in clocks, ≥1.
- `ENTRY_CYCLES`, default 16 — length of the door entry delay in clocks, ≥1.
- `SIREN_CYCLES`, default 64 — siren on-time in clocks, ≥1.
- `CNT_W`, default 8 — delay counter width; must hold max(param)−1.

Ports:
- `clk` input 1 — single clock.
- `rst_n` input 1 — asynchronous, active-low reset.
- `sensor` input 3 — raw asynchronous sensors; bit0 motion, bit1 door, bit2 window; active-high.
- `arm` input 1 — synchronous arm request, level-sampled each cycle.
- `disarm` input 1 — synchronous disarm request, level-sampled each cycle.
- `state` output 3 — current FSM state encoding.
- `armed` output 1 — high in ARMED or ENTRY.
- `siren` output 1 — high in ALARM only.
- `alarm_mem` output 1 — high in ALARM or HOLD.
- `buzzer` output 1 — high in EXIT or ENTRY (warning beeper).
- `zone` output 3 — sticky record of the sensors that caused or joined an alarm event.
- `arm_fault` output 1 — one-cycle pulse when an arm request is refused.

## Operation

- Each sensor bit passes through a 2-FF synchronizer. The FSM sees only the synchronized value `s`.
- States and encodings: DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4, HOLD=5. Codes 6 and 7 are illegal and go to DISARMED on the next edge.
- A shared down-counter `cnt` (CNT_W bits) is loaded on state entry.
- `disarm` has priority over everything. In any state other than DISARMED, `disarm` goes to DISARMED on the next edge. `zone` is retained.
- DISARMED:
  - `arm` with `s`==0: go to EXIT, load `cnt`=EXIT_CYCLES−1, clear `zone`.
  - `arm` with `s`≠0: stay in DISARMED and pulse `arm_fault`.
- EXIT: sensors are ignored. At `cnt`==0 go to ARMED; otherwise decrement.
- ARMED:
  - `s[0]|s[2]`: go to ALARM, load SIREN_CYCLES−1, `zone|=s`.
  - Else `s[1]`: go to ENTRY, load ENTRY_CYCLES−1, `zone|=s`.
  - Immediate zones win when they coincide with the door.
- ENTRY:
  - `s[0]|s[2]`: go to ALARM immediately.
  - At `cnt`==0: go to ALARM.
  - Otherwise decrement.
  - `zone|=s` every cycle.
- ALARM:
  - `zone|=s` every cycle.
  - At `cnt`==0 go to HOLD; otherwise decrement.
  - Sensor activity does not reload the counter.
- HOLD:
  - The siren is off.
  - Any `s`≠0 goes to ALARM, reloads SIREN_CYCLES−1 and does `zone|=s`.
- `arm` is ignored in every state except DISARMED.
- `arm` and `disarm` together: disarm wins. In DISARMED this is a no-op with no fault.

## Timing

- Reset values: `state`=0, `cnt`=0, synchronizers=0, `zone`=0, and all 1-bit outputs 0.
- All outputs are registered or are decodes of registered state. There is no combinational path from inputs to outputs.
- Sensor latency: a sensor that is high at edge k is visible in `s` after edge k+1. The FSM acts on it at edge k+2.
- `arm` or `disarm` sampled at edge k changes `state` after edge k.
- Delay lengths, for an accept at edge k:
  - EXIT is held for exactly EXIT_CYCLES cycles; ARMED after edge k+EXIT_CYCLES.
  - ENTRY lasts ENTRY_CYCLES cycles.
  - ALARM lasts SIREN_CYCLES cycles.
- `arm_fault` is high for exactly the one cycle after the refusing edge.
- Reset assertion mid-delay forces DISARMED immediately and asynchronously. There is no resumption.

## Structure

- Package `alarm_pkg` holds:
  - the state enum `alarm_state_t`;
  - zone index constants `Z_MOTION`=0, `Z_DOOR`=1, `Z_WINDOW`=2;
  - the state width constant.
- Sub-module `alarm_sync`: a parameterised-width 2-FF synchronizer with async active-low reset. It is instantiated once with width 3.
- FSM, counter and zone latch live in `alarm_sequencer`.

## Test plan

All scenarios use EXIT=4, ENTRY=3, SIREN=5.

- Reset and arm: `arm` pulsed with `sensor`=000. `buzzer`=1 for 4 cycles, then `state`=2, `armed`=1, `zone`=000.
- Window trip while ARMED, `sensor`=100 held: `siren` rises 2 edges after sampling. It stays high 5 cycles, then `state`=5, `siren`=0, `alarm_mem`=1, `zone`=100.
- Door trip, then `disarm` during ENTRY: `state`=3 for ≤3 cycles, then DISARMED. `siren` never rises and `zone`=010. A second run without disarm reaches ALARM after exactly 3 ENTRY cycles.
- Door and motion together (`sensor`=011) while ARMED: goes directly to ALARM, skipping ENTRY. `zone`=011.
- Arm refused with `sensor`=010 held: `arm_fault` is a 1-cycle pulse and `state` stays 0. `arm` and `disarm` high together in DISARMED: no fault, `state`=0.
- Re-trigger from HOLD: a motion pulse returns to ALARM with a full 5-cycle siren and `zone`=101. Asserting `rst_n`=0 mid-ALARM gives all outputs 0 immediately.
